// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state type, counter width and default bundle widths for
// the pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int unsigned PIPE_CNT_WIDTH = 32;

    localparam int unsigned ID_EX_WIDTH       = 433;
    localparam int unsigned ID_EX_CTRL_WIDTH  = 16;
    localparam int unsigned EX_MEM_WIDTH      = 146;
    localparam int unsigned EX_MEM_CTRL_WIDTH = 8;
    localparam int unsigned MEM_WB_WIDTH      = 104;
    localparam int unsigned MEM_WB_CTRL_WIDTH = 4;

endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: pair of saturating event counters (stall / bubble), cleared
// only by reset. RST_VAL sets the value loaded on reset.
module pipe_perf_cnt
    import pipe_pkg::*;
#(
    parameter logic [PIPE_CNT_WIDTH-1:0] RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall_inc,
    input  logic                      bubble_inc,
    output logic [PIPE_CNT_WIDTH-1:0] stall_cnt,
    output logic [PIPE_CNT_WIDTH-1:0] bubble_cnt
);

    logic [PIPE_CNT_WIDTH-1:0] stall_q, stall_d;
    logic [PIPE_CNT_WIDTH-1:0] bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (bubble_inc && (bubble_q != '1)) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q  <= RST_VAL;
            bubble_q <= RST_VAL;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with a 2-entry skid buffer,
// flush, and control-bit masking on bubbles. PIPE_STAGE_PERF_EN adds counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH      = ID_EX_WIDTH,
    parameter int unsigned CTRL_WIDTH = ID_EX_CTRL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PIPE_CNT_WIDTH-1:0] stall_cnt,
    output logic [PIPE_CNT_WIDTH-1:0] bubble_cnt
`endif
);

    // Shifting by CTRL_WIDTH == WIDTH yields an all-ones mask; 0 yields none.
    localparam logic [WIDTH-1:0] CTRL_MASK = ~({WIDTH{1'b1}} << CTRL_WIDTH);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire, out_fire;
    pipe_state_t      state;

    always_comb begin
        case ({skid_valid_q, main_valid_q})
            2'b01:   state = ONE;
            2'b11:   state = FULL;
            default: state = EMPTY;
        endcase
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_valid_d = 1'b1;
                        main_data_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                    end else if (out_fire) begin
                        main_valid_d = 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    // Empty stage must never present live control bits downstream.
    assign out_data = main_valid_q ? main_data_q : (main_data_q & ~CTRL_MASK);

    skid_implies_main: assert property (
        @(posedge clk) disable iff (!reset) skid_valid_q |-> main_valid_q
    );

`ifdef PIPE_STAGE_PERF_EN
    pipe_perf_cnt u_perf (
        .clk        (clk),
        .reset      (reset),
        .stall_inc  (main_valid_q & ~out_ready),
        .bubble_inc (~main_valid_q),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg with a queue-based
// reference model checked every cycle plus hand-computed expectations.
`timescale 1ns/1ps
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned W  = 433;
    localparam int unsigned CW = 16;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  bubble_cnt;
`endif
    logic         sat_inc = 1'b0;
    logic [31:0]  sat_stall;
    logic [31:0]  sat_bubble;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .CTRL_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    pipe_perf_cnt #(.RST_VAL(32'hFFFF_FFFE)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .stall_inc  (sat_inc),
        .bubble_inc (1'b0),
        .stall_cnt  (sat_stall),
        .bubble_cnt (sat_bubble)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a FIFO of at most two beats plus the last head value.
    logic [W-1:0]    mq[$];
    logic [W-1:0]    last_head = '0;
    longint unsigned m_stall   = 0;
    longint unsigned m_bubble  = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            last_head <= '0;
            m_stall   <= 0;
            m_bubble  <= 0;
        end else begin
            automatic bit was_valid = (mq.size() > 0);
            automatic bit fin       = in_valid && (mq.size() < 2);
            if (was_valid && !out_ready) m_stall <= m_stall + 1;
            if (!was_valid) m_bubble <= m_bubble + 1;
            if (flush) begin
                mq.delete();
            end else begin
                if (was_valid && out_ready) void'(mq.pop_front());
                if (fin) mq.push_back(in_data);
            end
            if (mq.size() > 0) last_head <= mq[0];
        end
    end

    function automatic logic [W-1:0] exp_data();
        logic [W-1:0] low16 = W'(16'hFFFF);
        if (mq.size() > 0) return mq[0];
        return last_head & ~low16;
    endfunction

    function automatic logic [W-1:0] sat32(input longint unsigned v);
        return (v > 64'hFFFF_FFFF) ? W'(32'hFFFF_FFFF) : W'(v);
    endfunction

    always @(negedge clk) begin
        chk("model_out_valid", W'(out_valid), W'(mq.size() > 0));
        chk("model_in_ready", W'(in_ready), W'(mq.size() < 2));
        chk("model_out_data", out_data, exp_data());
`ifdef PIPE_STAGE_PERF_EN
        chk("model_stall_cnt", W'(stall_cnt), sat32(m_stall));
        chk("model_bubble_cnt", W'(bubble_cnt), sat32(m_bubble));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] a, b, c, d, ones, exp;
        a = '0; a[W-1 -: 32] = 32'hDEAD_BEEF; a[15:0] = 16'hAAAA; a[100] = 1'b1;
        b = '0; b[W-1 -: 32] = 32'h1234_5678; b[15:0] = 16'h5555; b[200] = 1'b1;
        c = '0; c[W-1 -: 32] = 32'hCAFE_F00D; c[15:0] = 16'h0F0F;
        d = '0; d[W-1 -: 32] = 32'h0BAD_CAFE; d[15:0] = 16'hF00D;
        ones = '1;

        #2 reset = 1'b0;
        repeat (3) cyc();
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_in_ready", W'(in_ready), W'(1'b1));
        chk("rst_out_data", out_data, '0);
        reset = 1'b1;

        // Streaming: one beat per cycle, 1-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_data = W'(i);
            cyc();
            chk("stream_data", out_data, W'(i));
            chk("stream_valid", W'(out_valid), W'(1'b1));
            chk("stream_ready", W'(in_ready), W'(1'b1));
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_drain_valid", W'(out_valid), '0);
        chk("stream_drain_data", out_data, '0);

        // Back-pressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        cyc();
        chk("bp_a_ready", W'(in_ready), W'(1'b1));
        chk("bp_a_data", out_data, a);
        in_data = b;
        cyc();
        chk("bp_b_ready", W'(in_ready), '0);
        chk("bp_b_head", out_data, a);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("bp_pop_a_data", out_data, b);
        chk("bp_pop_a_ready", W'(in_ready), W'(1'b1));
        cyc();
        chk("bp_pop_b_valid", W'(out_valid), '0);

        // Flush while FULL, with C offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        cyc();
        in_data = b;
        cyc();
        in_data = c;
        flush   = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_valid", W'(out_valid), '0);
        chk("flush_ready", W'(in_ready), W'(1'b1));
        chk("flush_ctrl", W'(out_data[15:0]), '0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            cyc();
            chk("flush_no_c", W'(out_valid), '0);
        end

        // Bubble masking
        in_valid = 1'b1;
        in_data  = ones;
        cyc();
        chk("mask_live", out_data, ones);
        in_valid = 1'b0;
        cyc();
        exp = ones;
        exp[15:0] = 16'h0000;
        chk("mask_bubble", out_data, exp);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        cyc();
        in_data = b;
        cyc();
        in_valid = 1'b0;
        chk("areset_full", W'(in_ready), '0);
        #2 reset = 1'b0;
        #1;
        chk("areset_valid", W'(out_valid), '0);
        chk("areset_data", out_data, '0);
        chk("areset_ready", W'(in_ready), W'(1'b1));
        cyc();
        cyc();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        cyc();
        chk("post_reset_data", out_data, d);
        chk("post_reset_valid", W'(out_valid), W'(1'b1));
        in_valid = 1'b0;
        cyc();

`ifdef PIPE_STAGE_PERF_EN
        reset = 1'b0;
        cyc();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = a;
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
        chk("perf_stall5", W'(stall_cnt), W'(32'd5));
        out_ready = 1'b1;
        cyc();
        repeat (3) cyc();
        chk("perf_stall_hold", W'(stall_cnt), W'(32'd5));
        chk("perf_bubble", W'(bubble_cnt), W'(32'd4));
`endif

        // Saturation of the counter pair from a near-max reset value
        chk("sat_start", W'(sat_stall), W'(32'hFFFF_FFFE));
        sat_inc = 1'b1;
        repeat (3) begin
            cyc();
            chk("sat_hold", W'(sat_stall), W'(32'hFFFF_FFFF));
        end
        sat_inc = 1'b0;
        chk("sat_other", W'(sat_bubble), W'(32'hFFFF_FFFE));

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline stage register. It is the successor to the fixed-width, always-enabled ID/EX register.
- It carries an arbitrary packed payload between stages with a valid/ready handshake, and holds data on downstream back-pressure.
- It uses a 2-entry skid buffer so that in_ready is registered (no combinational ready path).
- A hazard-unit flush inserts bubbles. Control bits are forced to zero whenever the stage is empty, so an empty stage never writes the register file or memory.

Parameters:
- WIDTH, 433, payload width in bits (whole bundled stage word).
- CTRL_WIDTH, 16, number of low payload bits treated as control (RegWrite, memWrite, branch, ...); must be between 0 and WIDTH.

Ports:
- clk  input  1  stage clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all held beats (hazard/branch mispredict).
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat; registered.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream beat present.
- out_ready  input  1  downstream accepts beat.
- out_data  output  WIDTH  downstream payload.

Behaviour:
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Producer holds in_data stable while in_valid & ~in_ready.
- Storage: main register (drives out_data) and skid register, each with its own valid bit.
- State machine, derived from the two valid bits:
  - EMPTY: main and skid both invalid.
  - ONE: main valid, skid invalid.
  - FULL: main and skid both valid.
- Transitions when flush=0:
  - EMPTY: in_fire loads main and goes to ONE; otherwise stays EMPTY.
  - ONE, in_fire & out_fire: main <= in_data, stays ONE.
  - ONE, in_fire only: skid <= in_data, goes to FULL.
  - ONE, out_fire only: goes to EMPTY.
  - ONE, neither: holds.
  - FULL: in_ready=0. out_fire moves main <= skid and goes to ONE; otherwise holds.
- Outputs and latency:
  - in_ready = ~skid_valid, registered.
  - out_valid = main_valid.
  - Latency from EMPTY: 1 cycle (in_fire at edge N gives out_valid after edge N).
  - Sustained throughput: 1 beat/cycle.
  - Order is strictly FIFO; no beat is duplicated or dropped except by flush.
- Bubble masking:
  - out_data[CTRL_WIDTH-1:0] = 0 whenever out_valid=0.
  - out_data upper bits hold their last value when out_valid=0.
  - CTRL_WIDTH=0 disables masking.
- Flush:
  - Highest priority. The next edge clears both valid bits (state EMPTY) and sets in_ready=1.
  - Any beat offered in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as consumed by downstream.
  - Flush while EMPTY has no effect.
- Reset (asserted asynchronously, anytime including mid-transfer):
  - main/skid valid=0, all data registers=0, in_ready=1, out_valid=0, out_data=0.
  - Deassertion is synchronised externally; the first edge after release behaves as EMPTY.
- No X propagation: data registers load only on their enable conditions.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, the block adds output ports stall_cnt [31:0] and bubble_cnt [31:0].
  - stall_cnt counts cycles with out_valid & ~out_ready.
  - bubble_cnt counts cycles with ~out_valid.
  - Both counters saturate at all-ones, are cleared only by reset, and are unaffected by flush.
- When undefined, the ports and the counter logic do not exist.
- Core behaviour is identical either way.

Decomposition:
- Shared package pipe_pkg holds:
  - Enumerated typedef pipe_state_t {EMPTY, ONE, FULL}, used for assertions and debug visibility.
  - Constant PIPE_CNT_WIDTH = 32.
  - Default WIDTH/CTRL_WIDTH constants for the ID/EX, EX/MEM and MEM/WB bundles.
- One natural sub-module: pipe_perf_cnt (saturating counter pair). It is instantiated only under PIPE_STAGE_PERF_EN.

Test Plan:
- Streaming, WIDTH=433, CTRL_WIDTH=16: after reset, out_ready=1 and in_valid=1 with in_data=1,2,3,... per cycle. Expect out_data=1,2,3 one cycle later, in_ready constantly 1, no gaps.
- Back-pressure:
  - Send A then B with out_ready=0. After A, in_ready stays 1; after B is captured, in_ready=0.
  - Raise out_ready: expect A, then B, then out_valid=0. in_ready returns to 1 the cycle after A is consumed.
- Flush in FULL: with A and B held, pulse flush while in_valid=1 with C. Next cycle expect out_valid=0, in_ready=1, and out_data[15:0]=0. C never appears.
- Bubble masking: in_data=all-ones, consumed, then in_valid=0. Expect out_data[15:0]=16'h0000 and out_data[432:16] still all-ones.
- Async reset mid-transfer: assert reset between clock edges while FULL. Outputs clear immediately without a clock edge (out_valid=0, out_data=0, in_ready=1). After release, a new beat passes with 1-cycle latency.
- PIPE_STAGE_PERF_EN: 5 cycles with out_valid & ~out_ready, then 3 idle cycles. Expect stall_cnt=5 and bubble_cnt counting from reset release. Preload 32'hFFFFFFFE, stall 3 cycles, expect 32'hFFFFFFFF held.
